// File: rtl/eee_vid_pkg.sv
// eee_vid_pkg: shared constants and FSM state type for the horizontal video filter
package eee_vid_pkg;
    localparam int          IMAGE_W_DEF  = 640;
    localparam logic [31:0] ID_VALUE_DEF = 32'h1234EEE1;
    localparam logic [1:0]  REG_CTRL     = 2'd0;
    localparam logic [1:0]  REG_ID       = 2'd1;
    localparam logic [1:0]  REG_FRAMES   = 2'd2;
    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;
endpackage

// File: rtl/eee_hfilter_kernel.sv
// eee_hfilter_kernel: one-channel 3-tap (1,2,1)/4 smoothing, truncating
module eee_hfilter_kernel (
    input  logic [7:0] l,
    input  logic [7:0] c,
    input  logic [7:0] r,
    output logic [7:0] y
);
    logic [9:0] sum;
    assign sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r};
    assign y   = 8'(sum >> 2);
endmodule

// File: rtl/eee_hfilter.sv
// eee_hfilter: one-word-delay 3-tap horizontal filter on an Avalon-ST video stream; EEE_HFILTER_STATS_EN adds a frame counter
module eee_hfilter
    import eee_vid_pkg::*;
#(
    parameter int          IMAGE_W  = IMAGE_W_DEF,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [1:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    input  logic        mode
);
    localparam int             XW     = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam logic [XW-1:0]  X_LAST = XW'(IMAGE_W - 1);

    state_t        state, state_nxt;
    logic          out_free, accept, emit;
    logic [23:0]   h_data, p_data;
    logic          h_sop, h_eop;
    logic [XW-1:0] h_x, x_cnt;
    logic          packet_video, enable;
    logic [31:0]   frames, rd_data;
    logic          filt_on;
    logic [23:0]   l_data, r_data, y_data, f_data;
    logic          unused;

    assign unused = ^s_writedata[31:1];

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    // handshake, emission strobe and next state
    always_comb begin
        out_free   = ~source_valid | source_ready;
        sink_ready = (state != FLUSH) & out_free;
        accept     = sink_valid & sink_ready;
        emit       = 1'b0;
        state_nxt  = state;
        case (state)
            EMPTY: state_nxt = accept ? (sink_eop ? FLUSH : HOLD) : EMPTY;
            HOLD: begin
                emit      = accept;
                state_nxt = (accept & sink_eop) ? FLUSH : HOLD;
            end
            default: begin
                emit      = out_free;
                state_nxt = out_free ? EMPTY : FLUSH;
            end
        endcase
    end

    // taps with edge replication at row ends, packet ends and packet starts
    assign filt_on = mode & enable & packet_video & ~h_sop;
    assign l_data  = (h_x == '0) ? h_data : p_data;
    assign r_data  = ((state == FLUSH) | sink_sop | (h_x == X_LAST)) ? h_data : sink_data;
    assign f_data  = filt_on ? y_data : h_data;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        eee_hfilter_kernel u_kernel (
            .l (l_data[8*g +: 8]),
            .c (h_data[8*g +: 8]),
            .r (r_data[8*g +: 8]),
            .y (y_data[8*g +: 8])
        );
    end

    // held/previous word, pixel position tracking and output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_data  <= '0;
            h_data       <= '0;
            p_data       <= '0;
            h_sop        <= 1'b0;
            h_eop        <= 1'b0;
            h_x          <= '0;
            x_cnt        <= '0;
            packet_video <= 1'b0;
        end else begin
            if (emit) begin
                source_valid <= 1'b1;
                source_data  <= f_data;
                source_sop   <= h_sop;
                source_eop   <= h_eop;
            end else if (source_ready) begin
                source_valid <= 1'b0;
            end
            if (accept) begin
                p_data <= h_data;
                h_data <= sink_data;
                h_sop  <= sink_sop;
                h_eop  <= sink_eop;
                h_x    <= sink_sop ? '0 : x_cnt;
                x_cnt  <= (sink_sop | (x_cnt == X_LAST)) ? '0 : x_cnt + 1'b1;
                if (sink_sop) packet_video <= (sink_data[3:0] == 4'h0);
            end
        end
    end

`ifdef EEE_HFILTER_STATS_EN
    // count video packets as their eop word leaves the filter
    always_ff @(posedge clk) begin
        if (!reset_n)                        frames <= '0;
        else if (emit & h_eop & packet_video) frames <= frames + 32'd1;
    end
`else
    assign frames = '0;
`endif

    assign rd_data = (s_address == REG_CTRL)   ? {31'b0, enable} :
                     (s_address == REG_ID)     ? ID_VALUE :
                     (s_address == REG_FRAMES) ? frames : 32'd0;

    // control register and registered read port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable     <= 1'b1;
            s_readdata <= '0;
        end else begin
            if (s_chipselect & s_write & (s_address == REG_CTRL)) enable <= s_writedata[0];
            if (s_chipselect & s_read) s_readdata <= rd_data;
        end
    end
endmodule

// File: tb/tb_eee_hfilter.sv
// tb_eee_hfilter: randomized and directed checks of eee_hfilter against a packet-level reference model
module tb_eee_hfilter;
    localparam int W = 640;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
    logic [1:0]  s_address = '0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready = 1'b1;
    logic        mode = 1'b1;

    int          tests = 0, fails = 0;
    int          vid_frames = 0;
    bit          stall = 1'b0, rnd_ready = 1'b0;
    logic [23:0] pkt[$];
    logic [25:0] exp_q[$], got[$];
    logic [31:0] rd;

    eee_hfilter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_chipselect (s_chipselect),
        .s_read       (s_read),
        .s_write      (s_write),
        .s_address    (s_address),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready),
        .mode         (mode)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        source_ready = stall ? 1'b0 : (rnd_ready ? 1'($urandom_range(1)) : 1'b1);
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && source_valid && source_ready) got.push_back({source_sop, source_eop, source_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_write = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic send_word(input logic [23:0] d, input logic sop, input logic eop);
        int n = 0;
        if (rnd_ready && $urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
        end
        sink_valid = 1'b1; sink_data = d; sink_sop = sop; sink_eop = eop;
        @(negedge clk);
        while (!sink_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sink_ready) begin
            chk("sink_ready timeout", 32'(sink_ready), 32'd1);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], i == 0, i == pkt.size() - 1);
    endtask

    // expected stream: sop word untouched, pixels smoothed by (L+2C+R)/4 with replicated edges
    function automatic void model(input bit act);
        int n, x, c, l, r;
        bit video;
        logic [23:0] o;
        exp_q = {};
        n = pkt.size();
        video = (pkt[0][3:0] == 4'h0);
        for (int i = 0; i < n; i++) begin
            o = pkt[i];
            if (act && video && i > 0) begin
                x = (i - 1) % W;
                for (int ch = 0; ch < 3; ch++) begin
                    c = int'((pkt[i] >> (8 * ch)) & 24'hFF);
                    l = (x == 0) ? c : int'((pkt[i-1] >> (8 * ch)) & 24'hFF);
                    r = (x == W - 1 || i == n - 1) ? c : int'((pkt[i+1] >> (8 * ch)) & 24'hFF);
                    o[8*ch +: 8] = 8'((l + 2 * c + r) / 4);
                end
            end
            exp_q.push_back({i == 0, i == n - 1, o});
        end
    endfunction

    task automatic check_got(input string tag);
        int n = 0;
        while (got.size() < exp_q.size() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, " count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
        got = {};
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit act, input string tag);
        model(act);
        if (pkt[0][3:0] == 4'h0) vid_frames++;
        send_pkt();
        check_got(tag);
    endtask

    task automatic check_frames();
        read_reg(2'd2, rd);
`ifdef EEE_HFILTER_STATS_EN
        chk("frames", rd, 32'(vid_frames));
`else
        chk("frames", rd, 32'd0);
`endif
    endtask

    initial begin
        bit m, e;
        int len;
        logic [23:0] w;
        repeat (3) @(posedge clk);
        #1;
        chk("reset source_valid", 32'(source_valid), 32'd0);
        chk("reset source_data", 32'(source_data), 32'd0);
        reset_n = 1'b1;
        chk("reset sink_ready", 32'(sink_ready), 32'd1);
        read_reg(2'd0, rd); chk("ctrl reset", rd, 32'd1);
        read_reg(2'd1, rd); chk("id", rd, 32'h1234EEE1);
        read_reg(2'd2, rd); chk("frames reset", rd, 32'd0);
        read_reg(2'd3, rd); chk("reg3", rd, 32'd0);

        // G channel 0,40,80 -> 10,40,70
        pkt = {24'h000000, 24'h000000, 24'h002800, 24'h005000};
        exp_q = {26'h2000000, 26'h0000A00, 26'h0002800, 26'h1004600};
        vid_frames++;
        send_pkt();
        check_got("video G");

        // control packet passes bit-exact
        pkt = {24'h00000F, 24'($urandom), 24'($urandom), 24'($urandom)};
        run(1'b1, "control pkt");

        // stalled source while flushing a 2-word packet
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pkt = {24'h000000, 24'h123456};
        model(1'b1);
        vid_frames++;
        send_pkt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush sink_ready", 32'(sink_ready), 32'd0);
            chk("flush source_valid", 32'(source_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        check_got("stall pkt");

        // row boundary: x=639 then x=0 of the next row
        pkt = {24'h000000};
        for (int i = 0; i < W + 2; i++) pkt.push_back(24'($urandom));
        pkt[W][23:16] = 8'd200;
        pkt[W+1][23:16] = 8'd0;
        run(1'b1, "row boundary");

        // random packets, random mode/enable and backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            m = 1'($urandom_range(1));
            e = 1'($urandom_range(1));
            mode = m;
            write_reg(2'd0, {31'b0, e});
            len = $urandom_range(1, 14);
            w = 24'($urandom) & 24'hFFFFF0;
            if ($urandom_range(3) == 0) w[3:0] = 4'($urandom_range(1, 15));
            pkt = {w};
            for (int i = 1; i < len; i++) pkt.push_back(24'($urandom));
            run(m & e, "random pkt");
        end
        rnd_ready = 1'b0;
        check_frames();

        // enable off: video frame passes unchanged
        mode = 1'b1;
        write_reg(2'd0, 32'd0);
        read_reg(2'd0, rd); chk("ctrl write", rd, 32'd0);
        pkt = {24'h000000};
        for (int i = 0; i < 6; i++) pkt.push_back(24'($urandom));
        run(1'b0, "enable off");
        check_frames();
        write_reg(2'd0, 32'd1);

        // reset while holding a word mid-packet
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_word(24'h000000, 1'b1, 1'b0);
        send_word(24'h405060, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("post reset source_valid", 32'(source_valid), 32'd0);
        chk("post reset sink_ready", 32'(sink_ready), 32'd1);
        got = {};
        vid_frames = 0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        read_reg(2'd0, rd); chk("ctrl after reset", rd, 32'd1);
        pkt = {24'h000000};
        for (int i = 0; i < 5; i++) pkt.push_back(24'($urandom));
        run(1'b1, "after reset");
        check_frames();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eee_hfilter.md
EEE_HFILTER -- requirements
Module: eee_hfilter

Interface
REQ-001 Parameter IMAGE_W, 640, pixels per video row.
REQ-002 Parameter ID_VALUE, 32'h1234EEE1, constant returned at register 1.
REQ-003 clk  in  1  single clock; all logic posedge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 s_chipselect, s_read, s_write  in  1 each  MM slave strobes.
REQ-006 s_address  in  2  word address.
REQ-007 s_writedata  in  32, s_readdata  out  32 (registered).
REQ-008 sink_data  in  24, sink_valid  in  1, sink_sop  in  1, sink_eop  in  1, sink_ready  out  1: Avalon-ST video sink, {R,G,B}.
REQ-009 source_data  out  24, source_valid  out  1, source_sop  out  1, source_eop  out  1, source_ready  in  1: Avalon-ST source, ready latency 0.
REQ-010 mode  in  1  conduit; filtering is active only when mode=1 and CTRL.enable=1.

Function
REQ-011 The block sits directly upstream of the image processor and applies a per-channel 3-tap horizontal filter: out = (L + 2C + R) >> 2, with a 10-bit intermediate and truncation.
REQ-012 A word transfers on a port only when valid and ready are both 1 in the same cycle.
REQ-013 The stream leaves the block in the same order and count as it entered; each word is held one word before emission.
REQ-014 FSM states: EMPTY (nothing held), HOLD (word H held), FLUSH (held word carries eop).
REQ-015 EMPTY: on an accepted word N, H<=N and state goes to HOLD; nothing is emitted.
REQ-016 HOLD: on an accepted word N, emit f(P,H,N), then P<=H and H<=N; go to FLUSH if N has eop, otherwise stay in HOLD.
REQ-017 FLUSH: sink_ready=0; emit f(P,H,H); go to EMPTY when the output is accepted.
REQ-018 sink_ready = (state!=FLUSH) & (~source_valid | source_ready).
REQ-019 The sop word is never modified; on sop, packet_video <= (sink_data[3:0]==0) and the x counter resets to 0.
REQ-020 Non-sop words of video packets are filtered; words of non-video packets, and all words when filtering is inactive, pass unchanged.
REQ-021 Edge replicate rule: L<=C when H is at x=0; R<=C when H is at x=IMAGE_W-1 or when N has sop.
REQ-022 The x counter wraps from IMAGE_W-1 to 0 on each accepted non-sop pixel.
REQ-023 source_sop and source_eop travel unchanged with their own word.
REQ-024 Register 0 CTRL: bit0 enable (RW, reset 1).
REQ-025 Register 1: ID_VALUE (RO).
REQ-026 Register 2 FRAMES: frame counter (RO), see REQ-032.
REQ-027 Register 3 reads 0.
REQ-028 s_readdata updates the cycle after s_chipselect&s_read.
REQ-029 A write to CTRL takes effect from the next word emitted.

Reset
REQ-030 While reset_n=0 at clk:
- state<=EMPTY, source_valid<=0, source_sop/eop<=0, source_data<=0;
- s_readdata<=0, CTRL.enable<=1, x<=0, packet_video<=0, FRAMES<=0.
REQ-031 Reset asserted mid-packet discards held words; the next accepted word starts in EMPTY.

Configuration
REQ-032 With EEE_HFILTER_STATS_EN defined, FRAMES increments (wrapping at 2^32) on each emitted eop word of a video packet. Without the macro, FRAMES logic is absent and register 2 reads 0.

Structure
REQ-033 Shared package eee_vid_pkg holds:
- IMAGE_W default, register address constants, ID_VALUE default;
- the FSM state enum (EMPTY/HOLD/FLUSH).
REQ-034 Sub-module eee_hfilter_kernel holds the per-channel 3-tap arithmetic; it is instantiated three times (R, G, B).

Verification
REQ-035 Video packet, row pixels G = 0, 40, 80, with mode=1 -> G out = 10, 40, 70; sop word unchanged.
REQ-036 Control packet (sop word B[3:0]=0xF, 4 words), mode=1 -> all 4 words bit-exact on the source.
REQ-037 2-word packet with eop, source_ready held 0 for 5 cycles -> sink_ready=0 during FLUSH; both words emitted in order with no loss or duplication.
REQ-038 Row boundary: x=639 R=200, next-row x=0 R=0 -> x=639 output uses R-replicate (200), x=0 output uses L-replicate.
REQ-039 CTRL.enable written 0, then a video frame -> output equals input; FRAMES increments by 1 only with EEE_HFILTER_STATS_EN.
REQ-040 reset_n=0 for one cycle during HOLD -> source_valid=0 next cycle; the following packet is processed normally.
